// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: shared FSM state encoding and address helper for the RAM stream reader
package ram_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  // base + offset folded back into 0..depth-1; offset is always below depth
  function automatic int unsigned wrap_addr(input int unsigned base, input int unsigned offset, input int unsigned depth);
    return (base + offset >= depth) ? base + offset - depth : base + offset;
  endfunction
endpackage

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: valid/ready word stream
//   data  : stream word (master -> slave)
//   valid : word present (master -> slave)
//   ready : slave accepts; transfer when valid & ready
interface ram_stream_reader_if #(parameter int DATA_WIDTH = 8) ();
  logic [DATA_WIDTH-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, output valid, input ready);
  modport slave(input data, input valid, output ready);
endinterface

// File: rtl/ram_stream_reader_sync_fifo.sv
// ram_stream_reader_sync_fifo: small synchronous FIFO with registered storage, occupancy count and flush
//   clk, resetn : clock, asynchronous active-low reset
//   flush       : empties the FIFO, dropping any same-cycle push
//   push/din    : write side; ignored when full unless popping in the same cycle
//   pop         : read side; ignored when empty
//   dout/valid  : head word (0 when empty) and non-empty flag
//   count       : occupancy 0..DEPTH
module ram_stream_reader_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != (PW+1)'(DEPTH) || do_pop);
  assign valid = count != '0;
  assign dout = valid ? mem[rd] : '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + PW'(do_push);
      rd <= rd + PW'(do_pop);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr] <= din;
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads LENGTH consecutive words from a 1-cycle-latency RAM and streams them out in order
//   clk, resetn      : clock, asynchronous active-low reset
//   start, abort     : 1-cycle transfer request (IDLE only) / cancel of a running transfer
//   base_addr,length : first address and word count, latched on start
//   busy, done       : transfer in progress / 1-cycle completion pulse
//   ram_addr,ram_dout: RAM read address and registered read data
//   m                : output word stream (master)
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16384,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  ram_stream_reader_if.master      m
);
  localparam int CW = ADDRESS_WIDTH + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  logic [ADDRESS_WIDTH-1:0] base_q, addr_q, base_sel;
  logic [CW-1:0] len_q, issued, acked, offset;
  logic [FCW-1:0] fifo_count;
  logic inflight, issue, idle_go, abort_now, pop, last_ack, credit;
  assign idle_go = state == IDLE && start;
  assign abort_now = abort && (state == RUN || state == DRAIN);
  // in-flight word counts against FIFO space so a RAM read always has a slot to land in
  assign credit = ({1'b0, fifo_count} + (FCW+1)'(inflight)) < (FCW+1)'(FIFO_DEPTH);
  // the first read is issued in the start cycle itself, giving valid two cycles after start
  assign issue = (idle_go && length != '0) || (state == RUN && !abort && issued != len_q && credit);
  assign base_sel = state == IDLE ? base_addr : base_q;
  assign offset = state == IDLE ? '0 : issued;
  assign ram_addr = issue ? ADDRESS_WIDTH'(wrap_addr(32'(base_sel), 32'(offset), DEPTH)) : addr_q;
  assign pop = m.valid && m.ready;
  assign last_ack = pop && acked == len_q - CW'(1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    state_n = abort_now ? IDLE :
              state == IDLE ? (start ? (length == '0 ? DONE : RUN) : IDLE) :
              state == RUN ? (issued == len_q ? DRAIN : RUN) :
              state == DRAIN ? (last_ack ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      base_q <= '0;
      len_q <= '0;
      issued <= '0;
      acked <= '0;
      inflight <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      inflight <= issue;
      addr_q <= ram_addr;
      if (idle_go) begin
        base_q <= base_addr;
        len_q <= length;
        issued <= CW'(issue);
        acked <= '0;
      end else begin
        issued <= issued + CW'(issue);
        acked <= acked + CW'(pop);
      end
    end
  // abort flushes queued words and, via flush priority, the word arriving that cycle
  ram_stream_reader_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .flush(abort_now),
    .push(inflight),
    .pop(pop),
    .din(ram_dout),
    .dout(m.data),
    .valid(m.valid),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed self-checking bench for ram_stream_reader
module tb_ram_stream_reader;
  localparam int DEPTH = 16384;
  localparam int AW = 14;
  logic clk, resetn, start, abort, busy, done;
  logic [AW-1:0] base_addr, ram_addr;
  logic [AW:0] length;
  logic [7:0] ram_dout;
  logic [7:0] ram [DEPTH];
  int total, bad;
  ram_stream_reader_if #(.DATA_WIDTH(8)) s ();
  ram_stream_reader #(.DATA_WIDTH(8), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .m(s.master)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);
  always @(posedge clk) ram_dout <= ram[ram_addr];
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic kick(input int b, input int l);
    @(negedge clk);
    base_addr = AW'(b);
    length = (AW+1)'(l);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  initial begin
    int k, cyc, dn;
    logic stall, got_done;
    logic [7:0] held;
    total = 0; bad = 0;
    resetn = 0; start = 0; abort = 0; base_addr = '0; length = '0; s.ready = 1;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", s.valid, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", s.data, 0);
    @(negedge clk); @(negedge clk);
    resetn = 1;
    // 1: base 0x10, length 4, ready high
    kick(16'h10, 4);
    check("t1_busy", busy, 1);
    check("t1_lat_valid", s.valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_valid", s.valid, 1);
      check("t1_data", s.data, 32'h10 + i);
      check("t1_nodone", done, 0);
    end
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_empty", s.valid, 0);
    @(negedge clk);
    check("t1_done_off", done, 0);
    check("t1_idle", busy, 0);
    // 2: wrap from DEPTH-2
    kick(DEPTH - 2, 4);
    @(negedge clk); check("t2_w0", s.data, 8'hFE);
    @(negedge clk); check("t2_w1", s.data, 8'hFF);
    @(negedge clk); check("t2_w2", s.data, 8'h00);
    @(negedge clk); check("t2_w3", s.data, 8'h01);
    @(negedge clk); check("t2_done", done, 1);
    // 3: backpressure pattern 1,0,0,1 with random extra stalls
    kick(16'h40, 16);
    k = 0; cyc = 0; dn = 0; stall = 0; held = '0; got_done = 0;
    while (!got_done && cyc < 300) begin
      s.ready = (cyc % 4 == 0 || cyc % 4 == 3) && ($urandom_range(0, 4) != 0);
      if (stall) begin
        check("t3_stall_valid", s.valid, 1);
        check("t3_stall_data", s.data, held);
      end
      if (s.valid && s.ready) begin
        check("t3_word", s.data, 32'h40 + k);
        k++;
      end
      stall = s.valid && !s.ready;
      held = s.data;
      cyc++;
      @(negedge clk);
      if (done) begin
        got_done = 1;
        dn++;
      end
    end
    check("t3_count", k, 16);
    check("t3_done_seen", dn, 1);
    check("t3_empty", s.valid, 0);
    s.ready = 1;
    @(negedge clk);
    // 4: length 0
    kick(16'h33, 0);
    check("t4_done", done, 1);
    check("t4_valid", s.valid, 0);
    @(negedge clk);
    check("t4_done_off", done, 0);
    check("t4_idle", busy, 0);
    check("t4_valid2", s.valid, 0);
    // 5: abort with full FIFO, then a clean restart
    s.ready = 0;
    kick(16'h80, 16);
    repeat (5) @(negedge clk);
    check("t5_full_valid", s.valid, 1);
    check("t5_full_data", s.data, 8'h80);
    check("t5_full_busy", busy, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("t5_ab_valid", s.valid, 0);
    check("t5_ab_busy", busy, 0);
    check("t5_ab_done", done, 0);
    @(negedge clk);
    check("t5_ab_done2", done, 0);
    s.ready = 1;
    kick(16'h20, 2);
    @(negedge clk); check("t5_r0", s.data, 8'h20);
    @(negedge clk); check("t5_r1", s.data, 8'h21);
    @(negedge clk); check("t5_rdone", done, 1);
    // 6: async reset while draining
    s.ready = 0;
    kick(16'h00, 4);
    repeat (5) @(negedge clk);
    check("t6_pre_valid", s.valid, 1);
    #2 resetn = 0;
    #1;
    check("t6_valid", s.valid, 0);
    check("t6_busy", busy, 0);
    check("t6_addr", ram_addr, 0);
    check("t6_data", s.data, 0);
    @(negedge clk);
    resetn = 1;
    s.ready = 1;
    @(negedge clk);
    check("t6_post_valid", s.valid, 0);
    check("t6_post_busy", busy, 0);
    kick(16'h05, 1);
    @(negedge clk); check("t6_fresh", s.data, 8'h05);
    @(negedge clk); check("t6_done", done, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
